// File: rtl/fft_frame_loader.sv
// Double-buffered serial-to-parallel framer for the FFT core.
// Samples are streamed into one bank while the other is presented as a flat frame.
module fft_frame_loader #(
  parameter int DW     = 16,
  parameter int N      = 8,
  parameter int LOG2N  = 3,
  parameter int BITREV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [2*DW-1:0]       s_data,
  input  logic                  s_last,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [N*2*DW-1:0]     frame_data,
  output logic                  frame_padded,
  output logic [15:0]           frame_cnt
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  logic [2*DW-1:0]  r_bank [2][N];
  logic [1:0]       r_full;
  logic [1:0]       r_pad;
  logic             r_wr_sel;
  logic             r_rd_sel;
  logic [LOG2N-1:0] r_wr_idx;
  logic [15:0]      r_frame_cnt;

  logic             w_accept;
  logic             w_release;
  logic             w_close;
  logic [LOG2N-1:0] w_waddr;

  assign s_ready      = ~r_full[r_wr_sel];
  assign frame_valid  = r_full[r_rd_sel];
  assign frame_padded = r_pad[r_rd_sel];
  assign frame_cnt    = r_frame_cnt;

  assign w_accept  = s_valid & s_ready;
  assign w_release = frame_valid & frame_ready;
  assign w_close   = (r_wr_idx == LAST_IDX) | s_last;

  always_comb begin
    w_waddr = r_wr_idx;
    if (BITREV != 0) begin
      for (int unsigned b = 0; b < LOG2N; b++) begin
        w_waddr[b] = r_wr_idx[LOG2N-1-b];
      end
    end
  end

  always_comb begin
    frame_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      frame_data[i*2*DW +: 2*DW] = r_bank[r_rd_sel][i];
    end
  end

  // Releasing a bank clears it, which is what zero-pads an early-closed frame later.
  // Release and close always target different banks, so both may apply in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < N; i++) begin
          r_bank[b][i] <= '0;
        end
      end
      r_full      <= '0;
      r_pad       <= '0;
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_wr_idx    <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_release) begin
        for (int unsigned i = 0; i < N; i++) begin
          r_bank[r_rd_sel][i] <= '0;
        end
        r_full[r_rd_sel] <= 1'b0;
        r_pad[r_rd_sel]  <= 1'b0;
        r_rd_sel         <= ~r_rd_sel;
        r_frame_cnt      <= r_frame_cnt + 16'd1;
      end
      if (w_accept) begin
        r_bank[r_wr_sel][w_waddr] <= s_data;
        if (w_close) begin
          r_full[r_wr_sel] <= 1'b1;
          r_pad[r_wr_sel]  <= (r_wr_idx != LAST_IDX);
          r_wr_sel         <= ~r_wr_sel;
          r_wr_idx         <= '0;
        end else begin
          r_wr_idx <= r_wr_idx + LOG2N'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: natural and bit-reversed instances share one stimulus
// stream and are checked every cycle against a queue-of-frames model.
module tb_fft_frame_loader;
  localparam int DW = 16;
  localparam int N  = 8;
  localparam int LOG2N = 3;
  localparam int FW = N * 2 * DW;

  logic clk, rst, s_valid, s_last, frame_ready;
  logic [2*DW-1:0] s_data;

  logic          rdy0, fv0, fp0, rdy1, fv1, fp1;
  logic [FW-1:0] fd0, fd1;
  logic [15:0]   fc0, fc1;

  fft_frame_loader #(.DW(DW), .N(N), .LOG2N(LOG2N), .BITREV(0)) u_nat (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy0), .s_data(s_data),
    .s_last(s_last), .frame_valid(fv0), .frame_ready(frame_ready),
    .frame_data(fd0), .frame_padded(fp0), .frame_cnt(fc0));

  fft_frame_loader #(.DW(DW), .N(N), .LOG2N(LOG2N), .BITREV(1)) u_rev (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy1), .s_data(s_data),
    .s_last(s_last), .frame_valid(fv1), .frame_ready(frame_ready),
    .frame_data(fd1), .frame_padded(fp1), .frame_cnt(fc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done = 0;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: pending frames as a queue, partial frame as a list
  typedef struct {
    logic [FW-1:0] nat;
    logic [FW-1:0] rev;
    bit            pad;
  } frame_t;

  frame_t          q[$];
  logic [2*DW-1:0] part[N];
  int unsigned     pcnt = 0;
  logic [15:0]     m_cnt = '0;

  function automatic int unsigned rev_index(input int unsigned k);
    int unsigned r = 0;
    for (int b = 0; b < LOG2N; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  function automatic frame_t build(input int unsigned cnt, input bit pad);
    frame_t f;
    f.nat = '0;
    f.rev = '0;
    f.pad = pad;
    for (int unsigned k = 0; k < cnt; k++) begin
      f.nat[k*2*DW +: 2*DW] = part[k];
      f.rev[rev_index(k)*2*DW +: 2*DW] = part[k];
    end
    return f;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      pcnt  = 0;
      m_cnt = '0;
    end else begin
      bit acc, rel;
      acc = s_valid && (q.size() < 2);
      rel = (q.size() > 0) && frame_ready;
      if (rel) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (acc) begin
        part[pcnt] = s_data;
        pcnt++;
        if (pcnt == N || s_last) begin
          q.push_back(build(pcnt, pcnt != N));
          pcnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      frame_t e;
      if (q.size() > 0) e = q[0];
      else e = build(pcnt, 0);
      chk("m_ready0", FW'(rdy0), FW'(q.size() < 2));
      chk("m_ready1", FW'(rdy1), FW'(q.size() < 2));
      chk("m_valid0", FW'(fv0), FW'(q.size() > 0));
      chk("m_valid1", FW'(fv1), FW'(q.size() > 0));
      chk("m_pad0", FW'(fp0), FW'(e.pad));
      chk("m_pad1", FW'(fp1), FW'(e.pad));
      chk("m_data0", fd0, e.nat);
      chk("m_data1", fd1, e.rev);
      chk("m_cnt0", FW'(fc0), FW'(m_cnt));
      chk("m_cnt1", FW'(fc1), FW'(m_cnt));
    end
  end

  // ---------------- stimulus helpers
  task automatic send(input logic [2*DW-1:0] d, input logic l);
    bit got = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      got = rdy0;
      @(posedge clk);
      #1;
      if (got) break;
    end
    if (!got) begin
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] slot(input logic [FW-1:0] fd, input int i);
    return FW'(fd[i*2*DW +: 2*DW]);
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", FW'(rdy0), FW'(1));
    chk("rst_valid", FW'(fv0), FW'(0));
    chk("rst_data", fd0, '0);
    chk("rst_pad", FW'(fp0), FW'(0));
    chk("rst_cnt", FW'(fc0), FW'(0));
    rst = 1'b0;

    // natural and bit-reversed full frame
    frame_ready = 1'b1;
    for (int k = 0; k < 8; k++) send({16'(k + 1), 16'h0000}, 1'b0);
    chk("nat_valid", FW'(fv0), FW'(1));
    for (int i = 0; i < 8; i++) chk("nat_slot", slot(fd0, i), FW'((i + 1) << 16));
    chk("nat_pad", FW'(fp0), FW'(0));
    chk("rev_slot1", slot(fd1, 1), FW'(32'h0005_0000));
    chk("rev_slot3", slot(fd1, 3), FW'(32'h0007_0000));
    chk("rev_slot6", slot(fd1, 6), FW'(32'h0004_0000));
    chk("rev_slot0", slot(fd1, 0), FW'(32'h0001_0000));
    tick();
    chk("nat_cnt", FW'(fc0), FW'(1));
    chk("nat_valid_drop", FW'(fv0), FW'(0));

    // early s_last
    frame_ready = 1'b0;
    send(32'h0100_0000, 1'b0);
    send(32'h0200_0000, 1'b0);
    send(32'h0300_0000, 1'b1);
    chk("early_valid", FW'(fv0), FW'(1));
    chk("early_pad", FW'(fp0), FW'(1));
    chk("early_s0", slot(fd0, 0), FW'(32'h0100_0000));
    chk("early_s1", slot(fd0, 1), FW'(32'h0200_0000));
    chk("early_s2", slot(fd0, 2), FW'(32'h0300_0000));
    chk("early_zero", FW'(fd0[FW-1:3*2*DW]), '0);
    chk("early_rev4", slot(fd1, 4), FW'(32'h0200_0000));
    chk("early_rev2", slot(fd1, 2), FW'(32'h0300_0000));
    frame_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(32'hA000_0000 | k, 1'b0);
    for (int i = 0; i < 8; i++) chk("after_slot", slot(fd0, i), FW'(32'hA000_0000 | i));
    chk("after_pad", FW'(fp0), FW'(0));
    send(32'h0C00_0000, 1'b0);
    send(32'h0D00_0000, 1'b1);
    chk("reuse_s1", slot(fd0, 1), FW'(32'h0D00_0000));
    chk("reuse_s2", slot(fd0, 2), FW'(0));
    chk("reuse_pad", FW'(fp0), FW'(1));
    tick();
    chk("reuse_cnt", FW'(fc0), FW'(4));

    // backpressure: 24 samples, frames released one by one
    frame_ready = 1'b0;
    fork
      for (int k = 0; k < 24; k++) send(32'(((k / 8) + 1) << 16) | 32'(k % 8), 1'b0);
      begin
        repeat (20) tick();
        chk("bp_ready_low", FW'(rdy0), FW'(0));
        chk("bp_f1", slot(fd0, 0), FW'(32'h0001_0000));
        repeat (3) tick();
        chk("bp_stable", slot(fd0, 7), FW'(32'h0001_0007));
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
        chk("bp_ready_back", FW'(rdy0), FW'(1));
        chk("bp_f2", slot(fd0, 0), FW'(32'h0002_0000));
        repeat (12) tick();
        chk("bp_ready_low2", FW'(rdy0), FW'(0));
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
        chk("bp_f3", slot(fd0, 0), FW'(32'h0003_0000));
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
        chk("bp_empty", FW'(fv0), FW'(0));
      end
    join
    chk("bp_cnt", FW'(fc0), FW'(7));

    // back-to-back frames at full rate
    frame_ready = 1'b1;
    begin
      int vcyc[$];
      int drops = 0;
      fork
        for (int k = 0; k < 32; k++) send(32'hB000_0000 | k, 1'b0);
        for (int c = 0; c < 45; c++) begin
          @(negedge clk);
          if (fv0) vcyc.push_back(c);
          if (!rdy0) drops++;
        end
      join
      chk("b2b_drops", FW'(drops), FW'(0));
      chk("b2b_frames", FW'(vcyc.size()), FW'(4));
      if (vcyc.size() == 4)
        for (int j = 1; j < 4; j++) chk("b2b_spacing", FW'(vcyc[j] - vcyc[j-1]), FW'(8));
    end
    tick();
    chk("b2b_cnt", FW'(fc0), FW'(11));

    // reset in the middle of a frame
    for (int k = 0; k < 5; k++) send(32'hEE00_0000 | k, 1'b0);
    rst = 1'b1;
    tick();
    chk("mrst_valid", FW'(fv0), FW'(0));
    chk("mrst_data", fd0, '0);
    chk("mrst_pad", FW'(fp0), FW'(0));
    chk("mrst_cnt", FW'(fc0), FW'(0));
    chk("mrst_ready", FW'(rdy0), FW'(1));
    rst = 1'b0;
    tick();
    chk("mrst_data_after", fd0, '0);
    chk("mrst_valid_after", FW'(fv0), FW'(0));
    for (int k = 0; k < 8; k++) send(32'h5500_0000 | k, 1'b0);
    for (int i = 0; i < 8; i++) chk("mrst_slot", slot(fd0, i), FW'(32'h5500_0000 | i));
    tick();
    chk("mrst_final_cnt", FW'(fc0), FW'(1));

    @(negedge clk);
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
